alu_wb_queue: RTL and testbench

//  Decoupling queue between the ALU/system execution output and the shared scalar writeback port.

---
 rtl/drac_pkg.sv | 25 ++
 rtl/alu_wb_queue.sv | 107 ++++++++++
 tb/tb_alu_wb_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// rtl/drac_pkg.sv - shared core types for the scalar writeback path
package drac_pkg;

    // Default number of ALU results held ahead of the shared writeback port
    localparam int unsigned ALU_WB_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exe_exception_t;

    typedef struct packed {
        logic           valid;
        logic [63:0]    result;
        logic [4:0]     rd;
        logic [5:0]     prd;
        logic [11:0]    csr_addr;
        logic [3:0]     gl_index;
        logic [1:0]     chkp;
        exe_exception_t ex;
        logic [4:0]     fp_status;
        logic [7:0]     vl;
    } exe_wb_scalar_instr_t;

endpackage

// File: rtl/alu_wb_queue.sv
// rtl/alu_wb_queue.sv - in-order ALU result queue feeding the shared scalar writeback port
module alu_wb_queue
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH     = ALU_WB_QUEUE_DEPTH,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned AFULL_LVL = 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  exe_wb_scalar_instr_t   instr_i,
    input  logic                   wb_ready_i,
    output exe_wb_scalar_instr_t   instr_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_LVL);
    localparam logic          BYPASS_EN = (BYPASS != 0);

    exe_wb_scalar_instr_t mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full_q;
    logic          push;
    logic          pop;
    logic          bypass_take;

    // Decide this cycle's push/pop/bypass; flush overrides everything
    always_comb begin
        bypass_take = BYPASS_EN && instr_i.valid && (count == '0) && wb_ready_i && !flush_i;
        pop         = (count != '0) && wb_ready_i && !flush_i;
        // A full queue still accepts when the head leaves in the same cycle
        push        = instr_i.valid && !flush_i && !bypass_take && ((count != DEPTH_C) || pop);
        if (flush_i) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    // Pointer, occupancy and registered almost-full state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            count  <= count_next;
            // Registered from the next count so issue sees it one cycle early enough
            full_q <= (DEPTH_C - count_next) <= AFULL_C;
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Payload storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= instr_i;
        end
    end

    // Head entry, or the incoming result itself when the queue is empty and bypass is on
    always_comb begin
        instr_o       = mem[rd_ptr];
        instr_o.valid = (count != '0);
        if ((count == '0) && BYPASS_EN) begin
            instr_o = instr_i;
        end
        if (flush_i) begin
            instr_o.valid = 1'b0;
        end
    end

    assign full_o  = full_q;
    assign empty_o = (count == '0);
    assign count_o = count;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (instr_i.valid && !flush_i && (count == DEPTH_C)) |-> wb_ready_i);

    a_count_range: assert property (@(posedge clk_i) disable iff (!rstn_i)
        count <= DEPTH_C);

    a_head_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (instr_o.valid && !wb_ready_i && !flush_i) |=> (flush_i || $stable(instr_o)));

endmodule

// File: tb/tb_alu_wb_queue.sv
// tb/tb_alu_wb_queue.sv - randomized and directed bench for alu_wb_queue against a queue model
module tb_alu_wb_queue;
    import drac_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFULL = 1;

    logic                 clk;
    logic                 rstn_i;
    logic                 flush_i;
    exe_wb_scalar_instr_t instr_i;
    logic                 wb_ready_i;
    exe_wb_scalar_instr_t instr_o;
    logic                 full_o;
    logic                 empty_o;
    logic [2:0]           count_o;

    exe_wb_scalar_instr_t model_q [$];
    logic [63:0]          seq [$];
    int                   n_checks = 0;
    int                   n_pass   = 0;

    alu_wb_queue #(
        .DEPTH     (DEPTH),
        .BYPASS    (1),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .flush_i    (flush_i),
        .instr_i    (instr_i),
        .wb_ready_i (wb_ready_i),
        .instr_o    (instr_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exe_wb_scalar_instr_t rand_instr();
        exe_wb_scalar_instr_t r;
        r.valid     = 1'b0;
        r.result    = {$urandom(), $urandom()};
        r.rd        = 5'($urandom());
        r.prd       = 6'($urandom());
        r.csr_addr  = 12'($urandom());
        r.gl_index  = 4'($urandom());
        r.chkp      = 2'($urandom());
        r.ex        = 5'($urandom());
        r.fp_status = 5'($urandom());
        r.vl        = 8'($urandom());
        return r;
    endfunction

    // Compare every observable output with what the queue model says this cycle
    task automatic check_outputs();
        exe_wb_scalar_instr_t exp;
        logic                 exp_valid;
        exp       = '0;
        exp_valid = 1'b0;
        if (!flush_i) begin
            if (model_q.size() > 0) begin
                exp       = model_q[0];
                exp_valid = 1'b1;
            end else if (instr_i.valid) begin
                exp       = instr_i;
                exp_valid = 1'b1;
            end
        end
        check("valid", 128'(instr_o.valid), 128'(exp_valid));
        if (exp_valid) begin
            check("payload", 128'(instr_o), 128'(exp));
        end
        check("count", 128'(count_o), 128'(model_q.size()));
        check("empty", 128'(empty_o), 128'(model_q.size() == 0));
        check("full", 128'(full_o), 128'((DEPTH - model_q.size()) <= AFULL));
    endtask

    // Apply the clock edge to the model: flush clears, head retires on grant, bypass skips storage
    task automatic model_edge();
        logic took;
        if (flush_i) begin
            model_q.delete();
        end else begin
            took = 1'b0;
            if (model_q.size() > 0 && wb_ready_i) begin
                void'(model_q.pop_front());
            end else if (model_q.size() == 0 && instr_i.valid && wb_ready_i) begin
                took = 1'b1;
            end
            if (instr_i.valid && !took && model_q.size() < DEPTH) begin
                model_q.push_back(instr_i);
            end
        end
    endtask

    task automatic step(input logic v, input logic [63:0] res, input logic rdy, input logic fl,
                        output exe_wb_scalar_instr_t obs);
        exe_wb_scalar_instr_t in;
        @(negedge clk);
        in         = rand_instr();
        in.valid   = v;
        in.result  = res;
        instr_i    = in;
        wb_ready_i = rdy;
        flush_i    = fl;
        #1;
        obs = instr_o;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        exe_wb_scalar_instr_t obs;
        logic v;
        logic rdy;
        logic fl;

        rstn_i     = 1'b0;
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        instr_i    = '0;
        #12;
        check("rst_valid", 128'(instr_o.valid), 128'(0));
        check("rst_count", 128'(count_o), 128'(0));
        check("rst_empty", 128'(empty_o), 128'(1));
        check("rst_full", 128'(full_o), 128'(0));
        @(negedge clk);
        rstn_i = 1'b1;

        // Bypass on empty queue
        step(1'b1, 64'h1234, 1'b1, 1'b0, obs);
        check("byp_valid", 128'(obs.valid), 128'(1));
        check("byp_res", 128'(obs.result), 128'(64'h1234));
        #1 check("byp_count", 128'(count_o), 128'(0));

        // Fill with no grant, then drain in order
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 64'(k), 1'b0, 1'b0, obs);
            #1;
            check("fill_count", 128'(count_o), 128'(k));
            check("fill_full", 128'(full_o), 128'(k >= 3));
        end
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 64'h0, 1'b1, 1'b0, obs);
            check("drain_res", 128'(obs.result), 128'(k));
        end
        #1 check("drain_empty", 128'(empty_o), 128'(1));

        // Continuous push+pop at occupancy 2 across pointer wrap
        seq.delete();
        step(1'b1, 64'hA0, 1'b0, 1'b0, obs);
        seq.push_back(64'hA0);
        step(1'b1, 64'hA1, 1'b0, 1'b0, obs);
        seq.push_back(64'hA1);
        for (int i = 0; i < 10; i++) begin
            seq.push_back(64'h100 + 64'(i));
            step(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0, obs);
            check("wrap_res", 128'(obs.result), 128'(seq.pop_front()));
            #1 check("wrap_count", 128'(count_o), 128'(2));
        end

        // Push while full together with a pop
        step(1'b1, 64'h300, 1'b0, 1'b0, obs);
        step(1'b1, 64'h301, 1'b0, 1'b0, obs);
        step(1'b1, 64'h5, 1'b1, 1'b0, obs);
        check("fullpp_head", 128'(obs.result), 128'(64'h108));
        #1 check("fullpp_count", 128'(count_o), 128'(4));

        // Flush at occupancy 3 with a live input and grant
        step(1'b0, 64'h0, 1'b1, 1'b0, obs);
        step(1'b1, 64'h555, 1'b1, 1'b1, obs);
        check("flush_valid", 128'(obs.valid), 128'(0));
        #1 check("flush_count", 128'(count_o), 128'(0));
        step(1'b0, 64'h0, 1'b1, 1'b0, obs);
        check("flush_gone", 128'(obs.valid), 128'(0));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 15) == 0);
            if (model_q.size() == DEPTH && !rdy && !fl) begin
                v = 1'b0;
            end
            step(v, {$urandom(), $urandom()}, rdy, fl, obs);
        end

        // Asynchronous reset between edges at occupancy 2
        step(1'b0, 64'h0, 1'b0, 1'b1, obs);
        step(1'b1, 64'h61, 1'b0, 1'b0, obs);
        step(1'b1, 64'h62, 1'b0, 1'b0, obs);
        @(negedge clk);
        instr_i.valid = 1'b0;
        wb_ready_i    = 1'b0;
        flush_i       = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        check("arst_valid", 128'(instr_o.valid), 128'(0));
        check("arst_count", 128'(count_o), 128'(0));
        check("arst_empty", 128'(empty_o), 128'(1));
        check("arst_full", 128'(full_o), 128'(0));
        model_q.delete();
        @(negedge clk);
        rstn_i = 1'b1;
        step(1'b1, 64'h77, 1'b0, 1'b0, obs);
        step(1'b0, 64'h0, 1'b1, 1'b0, obs);
        check("post_rst_res", 128'(obs.result), 128'(64'h77));
        check("post_rst_valid", 128'(obs.valid), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
